// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller.
// Holds the PC, chooses the next fetch address (sequential, branch or jump),
// refuses out-of-range or misaligned targets, and sequences through
// IDLE -> RUN, stopping in HALT or FAULT until the next Reset.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 128
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] Immediate,
    input  logic [25:0] JumpAddr,
    input  logic        halt_req,
    output logic [31:0] IAddr,
    output logic        RW,
    output logic        fetch_valid,
    output logic        halted,
    output logic        addr_fault,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        HALT  = 2'b10,
        FAULT = 2'b11
    } state_t;

    // Highest byte address that still holds a whole instruction word.
    localparam logic [31:0] MAX_ADDR = 32'(IMEM_BYTES - 4);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] candidate;
    logic        advance;
    logic        bad_target;

    // Candidate next PC and its legality, computed from the current PC and inputs.
    always_comb begin
        // NOTE: every signal written here gets a value before any branch, so no path can infer a latch.
        pc_plus4      = pc + 32'd4;
        branch_target = pc_plus4 + {{14{Immediate[15]}}, Immediate, 2'b00};
        jump_target   = {pc_plus4[31:28], JumpAddr, 2'b00};
        candidate     = pc_plus4;
        case (PCSrc)
            2'b01:   candidate = branch_target;
            2'b10:   candidate = jump_target;
            default: candidate = pc_plus4;
        endcase
        advance    = PCWre && (PCSrc != 2'b11);
        bad_target = (candidate > MAX_ADDR) || (candidate[1:0] != 2'b00);
    end

    // State machine, PC register, fetch counter and registered status outputs.
    always_ff @(posedge CLK) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            fetch_count <= 16'd0;
            RW          <= 1'b0;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
            addr_fault  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= RUN;
                    RW          <= 1'b1;
                    fetch_valid <= 1'b1;
                end
                RUN: begin
                    if (halt_req) begin
                        // Halt wins over both a load and a fault in the same cycle.
                        state       <= HALT;
                        RW          <= 1'b0;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end else if (advance) begin
                        if (bad_target) begin
                            state       <= FAULT;
                            RW          <= 1'b0;
                            fetch_valid <= 1'b0;
                            addr_fault  <= 1'b1;
                        end else begin
                            pc <= candidate;
                            if (fetch_count != 16'hFFFF) begin
                                fetch_count <= fetch_count + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    // HALT and FAULT are terminal until Reset; everything stays frozen.
                    state <= state;
                end
            endcase
        end
    end

    assign IAddr = pc;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios, a randomized run
// against a behavioural model, and a counter-saturation run on a large-memory instance.
module tb_pc_fetch_ctrl;

    localparam longint MEM = 128;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        PCWre = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic [15:0] Immediate = 16'd0;
    logic [25:0] JumpAddr = 26'd0;
    logic        halt_req = 1'b0;

    logic [31:0] IAddr;
    logic        RW, fetch_valid, halted, addr_fault;
    logic [15:0] fetch_count;

    logic [31:0] b_iaddr;
    logic        b_rw, b_fetch_valid, b_halted, b_addr_fault;
    logic [15:0] b_fetch_count;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: a PC, a fetch count and one flag per mode.
    logic [31:0] m_pc = 32'd0;
    bit          m_idle = 1'b1, m_run = 1'b0, m_halt = 1'b0, m_fault = 1'b0;
    int          m_cnt = 0;

    always #5 CLK = ~CLK;

    pc_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_BYTES(128)) dut (
        .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc),
        .Immediate(Immediate), .JumpAddr(JumpAddr), .halt_req(halt_req),
        .IAddr(IAddr), .RW(RW), .fetch_valid(fetch_valid), .halted(halted),
        .addr_fault(addr_fault), .fetch_count(fetch_count)
    );

    pc_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_BYTES(1 << 20)) dut_big (
        .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc),
        .Immediate(Immediate), .JumpAddr(JumpAddr), .halt_req(halt_req),
        .IAddr(b_iaddr), .RW(b_rw), .fetch_valid(b_fetch_valid), .halted(b_halted),
        .addr_fault(b_addr_fault), .fetch_count(b_fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        longint seq, nxt;
        if (Reset) begin
            m_pc = 32'd0; m_idle = 1'b1; m_run = 1'b0; m_halt = 1'b0; m_fault = 1'b0; m_cnt = 0;
        end else if (m_idle) begin
            m_idle = 1'b0; m_run = 1'b1;
        end else if (m_run) begin
            if (halt_req) begin
                m_run = 1'b0; m_halt = 1'b1;
            end else if (PCWre && PCSrc != 2'b11) begin
                seq = (longint'(m_pc) + 4) & 64'hFFFF_FFFF;
                case (PCSrc)
                    2'b00:   nxt = seq;
                    2'b01:   nxt = (seq + longint'($signed(Immediate)) * 4) & 64'hFFFF_FFFF;
                    default: nxt = (seq & 64'hF000_0000) | (longint'(JumpAddr) * 4);
                endcase
                if (nxt > MEM - 4 || nxt % 4 != 0) begin
                    m_run = 1'b0; m_fault = 1'b1;
                end else begin
                    m_pc = nxt[31:0];
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        check("iaddr", IAddr, m_pc);
        check("rw", 32'(RW), 32'(m_run));
        check("fetch_valid", 32'(fetch_valid), 32'(m_run));
        check("halted", 32'(halted), 32'(m_halt));
        check("addr_fault", 32'(addr_fault), 32'(m_fault));
        check("fetch_count", 32'(fetch_count), 32'(m_cnt));
    endtask

    task automatic step(input bit rst, input bit we, input logic [1:0] src,
                        input logic [15:0] imm, input logic [25:0] ja, input bit hr);
        Reset = rst; PCWre = we; PCSrc = src; Immediate = imm; JumpAddr = ja; halt_req = hr;
        cycle();
    endtask

    initial begin
        // Reset state.
        step(1, 0, 2'b00, 16'd0, 26'd0, 0);
        check("rst_iaddr", IAddr, 32'd0);
        check("rst_rw_idle", 32'(RW), 32'd0);
        check("rst_count", 32'(fetch_count), 32'd0);

        // Sequential run: IDLE cycle, then 0,4,8,12,16.
        for (int i = 0; i < 5; i++) step(0, 1, 2'b00, 16'd0, 26'd0, 0);
        check("seq_iaddr", IAddr, 32'd16);
        check("seq_count", 32'(fetch_count), 32'd4);

        // Branches: 8 -> 4 with offset -2 words, then 4 -> 20 with offset +3.
        step(1, 0, 2'b00, 16'd0, 26'd0, 0);
        step(0, 1, 2'b00, 16'd0, 26'd0, 0);
        step(0, 1, 2'b00, 16'd0, 26'd0, 0);
        step(0, 1, 2'b00, 16'd0, 26'd0, 0);
        check("pre_branch_iaddr", IAddr, 32'd8);
        step(0, 1, 2'b01, 16'hFFFE, 26'd0, 0);
        check("branch_back", IAddr, 32'd4);
        step(0, 1, 2'b01, 16'd3, 26'd0, 0);
        check("branch_fwd", IAddr, 32'd20);

        // Jump to the last legal word, then fault on the step past it.
        step(1, 0, 2'b00, 16'd0, 26'd0, 0);
        step(0, 0, 2'b00, 16'd0, 26'd0, 0);
        step(0, 1, 2'b10, 16'd0, 26'd31, 0);
        check("jump_iaddr", IAddr, 32'd124);
        step(0, 1, 2'b00, 16'd0, 26'd0, 0);
        check("fault_iaddr", IAddr, 32'd124);
        check("fault_flag", 32'(addr_fault), 32'd1);
        check("fault_rw", 32'(RW), 32'd0);
        step(0, 1, 2'b01, 16'd2, 26'd0, 0);
        check("fault_frozen_count", 32'(fetch_count), 32'd1);

        // Reset out of FAULT, then RUN at address 0.
        step(1, 1, 2'b00, 16'd0, 26'd0, 0);
        check("rst_fault_iaddr", IAddr, 32'd0);
        check("rst_fault_flag", 32'(addr_fault), 32'd0);
        step(0, 0, 2'b00, 16'd0, 26'd0, 0);
        check("run_after_rst", 32'(RW), 32'd1);

        // Hold cycles, then halt with PCWre asserted.
        step(0, 1, 2'b00, 16'd0, 26'd0, 0);
        step(0, 1, 2'b00, 16'd0, 26'd0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 16'd0, 26'd0, 0);
        step(0, 1, 2'b11, 16'd0, 26'd0, 0);
        check("hold_iaddr", IAddr, 32'd8);
        check("hold_count", 32'(fetch_count), 32'd2);
        step(0, 1, 2'b00, 16'd0, 26'd0, 1);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_iaddr", IAddr, 32'd8);
        check("halt_count", 32'(fetch_count), 32'd2);
        step(0, 1, 2'b00, 16'd0, 26'd0, 0);
        step(0, 1, 2'b10, 16'd0, 26'd5, 0);
        check("halt_frozen", IAddr, 32'd8);

        // Reset out of HALT, then halt takes priority over a faulting step.
        step(1, 1, 2'b01, 16'hFFFE, 26'd0, 1);
        check("rst_halt_flag", 32'(halted), 32'd0);
        step(0, 0, 2'b00, 16'd0, 26'd0, 0);
        step(0, 1, 2'b10, 16'd0, 26'd31, 0);
        step(0, 1, 2'b00, 16'd0, 26'd0, 1);
        check("halt_over_fault_h", 32'(halted), 32'd1);
        check("halt_over_fault_f", 32'(addr_fault), 32'd0);

        // Randomized run against the model.
        step(1, 0, 2'b00, 16'd0, 26'd0, 0);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0,
                 2'($urandom_range(0, 3)),
                 16'($signed($urandom_range(0, 20)) - 10),
                 26'($urandom_range(0, 40)),
                 $urandom_range(0, 59) == 0);
        end

        // Counter saturation on the large-memory instance.
        step(1, 0, 2'b00, 16'd0, 26'd0, 0);
        check("big_rst_iaddr", b_iaddr, 32'd0);
        Reset = 1'b0; PCWre = 1'b1; PCSrc = 2'b00; halt_req = 1'b0;
        repeat (65536) @(posedge CLK);
        #1;
        check("big_count_max", 32'(b_fetch_count), 32'd65535);
        check("big_iaddr_max", b_iaddr, 32'd262140);
        repeat (5) @(posedge CLK);
        #1;
        check("big_count_sat", 32'(b_fetch_count), 32'd65535);
        check("big_iaddr_end", b_iaddr, 32'd262160);
        check("big_valid", 32'(b_fetch_valid), 32'd1);
        check("big_no_fault", 32'(b_addr_fault), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address loaded into the PC on reset.
REQ-002 Parameter IMEM_BYTES, default 128, instruction-memory size in bytes; legal fetch addresses are 0..IMEM_BYTES-4.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 PCWre  input  1  PC write enable; 1 = advance the PC this cycle, 0 = hold.
REQ-006 PCSrc  input  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 hold.
REQ-007 Immediate  input  16  signed branch offset in words.
REQ-008 JumpAddr  input  26  jump target field (word index).
REQ-009 halt_req  input  1  request to stop fetching.
REQ-010 IAddr  output  32  current PC, byte address presented to instruction memory.
REQ-011 RW  output  1  instruction-memory read strobe (1 = read, 0 = idle).
REQ-012 fetch_valid  output  1  IAddr holds a legal address in RUN state.
REQ-013 halted  output  1  block is in HALT state.
REQ-014 addr_fault  output  1  block is in FAULT state.
REQ-015 fetch_count  output  16  number of accepted PC advances, saturating.

Function
REQ-016 States SHALL be IDLE, RUN, HALT, FAULT; all outputs SHALL be registered or decoded only from state and PC.
REQ-017 IDLE SHALL last exactly one cycle after Reset deasserts, with RW=0 and fetch_valid=0, then go to RUN unconditionally.
REQ-018 In RUN, RW=1 and fetch_valid=1.
REQ-019 In RUN, the PC SHALL update only when PCWre=1 and PCSrc!=11; otherwise it SHALL hold.
REQ-020 PC+4 SHALL be computed modulo 2^32.
REQ-021 Sequential next PC (PCSrc=00) SHALL be PC+4.
REQ-022 Branch next PC (PCSrc=01) SHALL be PC+4 + (sign-extended Immediate << 2), computed modulo 2^32.
REQ-023 Jump next PC (PCSrc=10) SHALL be {PC+4[31:28], JumpAddr, 2'b00}.
REQ-024 A candidate next PC > IMEM_BYTES-4 SHALL NOT be loaded; the PC SHALL hold and the state SHALL go to FAULT.
REQ-025 A candidate next PC with bits [1:0] != 0 SHALL likewise NOT be loaded; the PC SHALL hold and the state SHALL go to FAULT.
REQ-026 halt_req=1 in RUN SHALL move the state to HALT on the next edge; no PC update occurs that cycle, even if PCWre=1.
REQ-027 halt_req SHALL take priority over a simultaneous fault.
REQ-028 HALT and FAULT SHALL be terminal until Reset, with RW=0, fetch_valid=0, PC frozen and fetch_count frozen.
REQ-029 fetch_count SHALL increment by 1 on each PC load in RUN and SHALL saturate at 16'hFFFF.
REQ-030 Hold cycles (PCWre=0 or PCSrc=11) SHALL NOT increment fetch_count.
REQ-031 IAddr SHALL always equal the PC register; the instruction word is available from instruction memory combinationally in the same cycle.
REQ-032 Latency: a PC load requested in cycle N SHALL appear on IAddr in cycle N+1.

Reset
REQ-033 Reset=1 SHALL, on the next edge, set PC=RESET_PC, state=IDLE, fetch_count=0, RW=0, fetch_valid=0, halted=0, addr_fault=0.
REQ-034 Reset SHALL override every other input in any state, including mid-branch, HALT and FAULT.

Verification
REQ-035 Sequential run: reset, then PCWre=1, PCSrc=00 for 5 cycles -> IAddr sequence 0,0(IDLE),4,8,12,16; fetch_count=4 after the last step; RW=0 only during IDLE.
REQ-036 Branch: at PC=8, Immediate=16'hFFFE, PCSrc=01 -> IAddr=4 next cycle.
REQ-037 Branch: at PC=4, Immediate=3 -> IAddr=20.
REQ-038 Jump and fault: at PC=0, JumpAddr=26'd31, PCSrc=10 -> IAddr=124.
REQ-039 Jump and fault: sequential step from PC=124 -> PC holds at 124, addr_fault=1, RW=0.
REQ-040 Hold and halt: PCWre=0 for 3 cycles -> IAddr and fetch_count unchanged; then halt_req=1 together with PCWre=1 -> halted=1, IAddr unchanged, fetch_count unchanged.
REQ-041 Reset mid-operation: assert Reset during FAULT with PC=124 -> next cycle PC=0, addr_fault=0, IDLE; RUN with IAddr=0 one cycle later.
REQ-042 Saturation: drive 65,540 sequential loads with IMEM_BYTES overridden to 2^20 -> fetch_count stays 16'hFFFF.
